// File: rtl/alu_issue_stage_pkg.sv
// Shared types and RV32I decode constants for the ALU issue stage.
package alu_issue_stage_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      AluAdd  = 4'd0,
      AluSub  = 4'd1,
      AluSll  = 4'd2,
      AluSlt  = 4'd3,
      AluSltu = 4'd4,
      AluXor  = 4'd5,
      AluSrl  = 4'd6,
      AluSra  = 4'd7,
      AluOr   = 4'd8,
      AluAnd  = 4'd9,
      AluAddu = 4'd10, // reserved, never produced by RV32I decode
      AluSubu = 4'd11  // reserved, never produced by RV32I decode
   } alu_op_e;

   // RV32I major opcodes
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   localparam logic [6:0] F7Base = 7'h00;
   localparam logic [6:0] F7Alt  = 7'h20;

   typedef struct packed {
      alu_op_e           alu_op;
      logic [XLEN-1:0]   lhs;
      logic [XLEN-1:0]   rhs;
      logic [4:0]        rd;
      logic              wb_en;
      logic              illegal;
   } issue_t;

   localparam issue_t IssueRst = '{alu_op: AluAdd, lhs: '0, rhs: '0, rd: '0,
                                   wb_en: 1'b0, illegal: 1'b0};

   // Register/immediate ALU op from funct3; alt selects SUB/SRA.
   function automatic alu_op_e f3_op(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      unique case (f3)
         3'd0:    op = alt ? AluSub : AluAdd;
         3'd1:    op = AluSll;
         3'd2:    op = AluSlt;
         3'd3:    op = AluSltu;
         3'd4:    op = AluXor;
         3'd5:    op = alt ? AluSra : AluSrl;
         3'd6:    op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream/downstream handshake bundle of the ALU issue stage.
interface alu_issue_stage_if;
   import alu_issue_stage_pkg::*;

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   instr;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              out_valid;
   logic              out_ready;
   alu_op_e           alu_op;
   logic [XLEN-1:0]   alu_lhs;
   logic [XLEN-1:0]   alu_rhs;
   logic [4:0]        out_rd;
   logic              out_wb_en;
   logic              out_illegal;

   // The issue stage itself
   modport slave (
      input  flush, in_valid, instr, pc, rs1_data, rs2_data,
             wb_valid, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, alu_op, alu_lhs, alu_rhs, out_rd, out_wb_en, out_illegal
   );

   // Fetch/regfile side plus the consuming ALU
   modport master (
      output flush, in_valid, instr, pc, rs1_data, rs2_data,
             wb_valid, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, alu_op, alu_lhs, alu_rhs, out_rd, out_wb_en, out_illegal
   );

endinterface

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decode: instruction and operands to ALU op/operands.
module alu_issue_stage_decoder
   import alu_issue_stage_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output issue_t          dec
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] i_imm;
   logic [XLEN-1:0] s_imm;
   logic [XLEN-1:0] u_imm;
   logic            unused_rs_idx;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign i_imm  = {{20{instr[31]}}, instr[31:20]};
   assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign u_imm  = {instr[31:12], 12'b0};
   // Source indices are only needed by the bypass muxes in the parent.
   assign unused_rs_idx = ^instr[19:15];

   // Decode opcode/funct fields, then squash illegal and x0 writes.
   always_comb begin
      dec         = IssueRst;
      dec.rd      = instr[11:7];
      case (opcode)
         OpcOp: begin
            if (f7 == F7Base || (f7 == F7Alt && (f3 == 3'd0 || f3 == 3'd5))) begin
               dec.alu_op = f3_op(f3, instr[30]);
               dec.lhs    = rs1;
               dec.rhs    = rs2;
               dec.wb_en  = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OpcOpImm: begin
            dec.lhs   = rs1;
            dec.wb_en = 1'b1;
            if (f3 == 3'd1) begin
               dec.alu_op  = AluSll;
               dec.rhs     = {27'b0, instr[24:20]};
               dec.illegal = (f7 != F7Base);
            end else if (f3 == 3'd5) begin
               dec.alu_op  = instr[30] ? AluSra : AluSrl;
               dec.rhs     = {27'b0, instr[24:20]};
               dec.illegal = (f7 != F7Base) && (f7 != F7Alt);
            end else begin
               dec.alu_op = f3_op(f3, 1'b0);
               dec.rhs    = i_imm;
            end
         end
         OpcLui: begin
            dec.rhs   = u_imm;
            dec.wb_en = 1'b1;
         end
         OpcAuipc: begin
            dec.lhs   = pc;
            dec.rhs   = u_imm;
            dec.wb_en = 1'b1;
         end
         OpcJal, OpcJalr: begin
            // Link value pc+4
            dec.lhs     = pc;
            dec.rhs     = 32'd4;
            dec.wb_en   = 1'b1;
            dec.illegal = (opcode == OpcJalr) && (f3 != 3'd0);
         end
         OpcLoad: begin
            dec.lhs     = rs1;
            dec.rhs     = i_imm;
            dec.illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OpcStore: begin
            dec.lhs     = rs1;
            dec.rhs     = s_imm;
            dec.illegal = (f3 > 3'd2);
         end
         OpcBranch: begin
            dec.lhs = rs1;
            dec.rhs = rs2;
            unique case (f3[2:1])
               2'b00:   dec.alu_op = AluSub;
               2'b10:   dec.alu_op = AluSlt;
               2'b11:   dec.alu_op = AluSltu;
               default: dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
      if (dec.illegal) begin
         dec.alu_op = AluAdd;
         dec.lhs    = '0;
         dec.rhs    = '0;
         dec.wb_en  = 1'b0;
      end
      if (dec.rd == 5'd0) begin
         dec.wb_en = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU through a single-entry valid/ready register.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_issue_stage_if.slave      bus
);

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            accept;
   logic            valid_q;
   issue_t          issue_q;
   issue_t          dec;

   assign bus.in_ready = !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // Forward the in-flight writeback onto matching sources; x0 is never forwarded.
   always_comb begin
      rs1_fwd = bus.rs1_data;
      rs2_fwd = bus.rs2_data;
      if (BYPASS_EN && bus.wb_valid && bus.wb_rd != 5'd0) begin
         if (bus.wb_rd == bus.instr[19:15]) rs1_fwd = bus.wb_data;
         if (bus.wb_rd == bus.instr[24:20]) rs2_fwd = bus.wb_data;
      end
   end

   alu_issue_stage_decoder u_decoder (
      .instr (bus.instr),
      .pc    (bus.pc),
      .rs1   (rs1_fwd),
      .rs2   (rs2_fwd),
      .dec   (dec)
   );

   // Issue register: flush beats accept beats drain; otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         issue_q <= IssueRst;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         issue_q <= dec;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.alu_op      = issue_q.alu_op;
   assign bus.alu_lhs     = issue_q.lhs;
   assign bus.alu_rhs     = issue_q.rhs;
   assign bus.out_rd      = issue_q.rd;
   assign bus.out_wb_en   = issue_q.wb_en;
   assign bus.out_illegal = issue_q.illegal;

endmodule
